// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encoding and forwarding-select codes for the pipeline hazard controller.
// Latency: n/a (types only). Backpressure: n/a.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LD_BUBBLE = 2'd1,
    REDIRECT  = 2'd2,
    MEM_WAIT  = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

endpackage

// File: rtl/forward_unit.sv
// Decode-stage operand forwarding selects; the youngest in-flight producer wins.
// Latency: purely combinational. Backpressure: none.
module forward_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int RegAddress = 5
) (
  input  logic                  id_valid,
  input  logic [RegAddress-1:0] id_rs1,
  input  logic [RegAddress-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_load,
  input  logic                  ex_reg_write,
  input  logic [RegAddress-1:0] ex_rd,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [RegAddress-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_reg_write,
  input  logic [RegAddress-1:0] wb_rd,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  logic ex_src, mem_src, wb_src;

  // A load in EX has no data yet; that case is covered by the load-use bubble.
  assign ex_src  = ex_valid & ex_reg_write & ~ex_load;
  assign mem_src = mem_valid & mem_reg_write;
  assign wb_src  = wb_valid & wb_reg_write;

  function automatic logic [1:0] pick(
    input logic [RegAddress-1:0] rs,
    input logic                  use_rs,
    input logic                  live_id,
    input logic                  ex_ok,
    input logic                  mem_ok,
    input logic                  wb_ok,
    input logic [RegAddress-1:0] exr,
    input logic [RegAddress-1:0] memr,
    input logic [RegAddress-1:0] wbr
  );
    logic live;
    live = live_id & use_rs & (rs != '0);
    if (live & ex_ok & (exr == rs))   return FWD_EX;
    if (live & mem_ok & (memr == rs)) return FWD_MEM;
    if (live & wb_ok & (wbr == rs))   return FWD_WB;
    return FWD_RF;
  endfunction

  assign fwd_a_sel = pick(id_rs1, id_use_rs1, id_valid, ex_src, mem_src, wb_src, ex_rd, mem_rd, wb_rd);
  assign fwd_b_sel = pick(id_rs2, id_use_rs2, id_valid, ex_src, mem_src, wb_src, ex_rd, mem_rd, wb_rd);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stall, flush and forwarding selects for the 5-stage RV32I pipeline.
// Latency: outputs combinational from state+inputs, state on clk. Backpressure: a dmem wait freezes every stage.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RegAddress  = 5,
  parameter int FlushCycles = 2,
  parameter int MemWaitMax  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [RegAddress-1:0] id_rs1,
  input  logic [RegAddress-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_load,
  input  logic                  ex_reg_write,
  input  logic [RegAddress-1:0] ex_rd,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [RegAddress-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_reg_write,
  input  logic [RegAddress-1:0] wb_rd,
  input  logic                  redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  mem_timeout,
  output logic [1:0]            ctrl_state
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FlushCycles - 1);
  localparam logic [7:0] WAIT_MAX     = 8'(MemWaitMax);

  ctrl_state_e state, state_nxt;
  logic [2:0]  flush_cnt, flush_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic        timeout_nxt;
  logic        stall_all, stall_front, flush_ifid, flush_idex;
  logic        mem_busy, redir, hit_rs1, hit_rs2, load_use;
  logic [1:0]  fwd_a_raw, fwd_b_raw;

  assign mem_busy = dmem_req & ~dmem_ready;
  assign redir    = redirect & ex_valid;
  assign hit_rs1  = id_valid & id_use_rs1 & (ex_rd == id_rs1) & (ex_rd != '0);
  assign hit_rs2  = id_valid & id_use_rs2 & (ex_rd == id_rs2) & (ex_rd != '0);
  assign load_use = ex_valid & ex_load & ex_reg_write & (hit_rs1 | hit_rs2);

  always_comb begin
    state_nxt   = state;
    flush_nxt   = flush_cnt;
    wait_nxt    = wait_cnt;
    timeout_nxt = mem_timeout;
    stall_all   = 1'b0;
    stall_front = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    if (state == MEM_WAIT) begin
      // A redirect held during the wait is picked up in the first RUN cycle.
      if (mem_busy) begin
        stall_all   = 1'b1;
        wait_nxt    = (wait_cnt < WAIT_MAX) ? wait_cnt + 8'd1 : WAIT_MAX;
        timeout_nxt = mem_timeout | (wait_nxt == WAIT_MAX);
      end else begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    end else if (mem_busy) begin
      stall_all   = 1'b1;
      state_nxt   = MEM_WAIT;
      wait_nxt    = 8'd1;
      flush_nxt   = '0;
      timeout_nxt = mem_timeout | (WAIT_MAX == 8'd1);
    end else if (redir) begin
      // Younger instructions are squashed, so a coincident load-use needs no stall.
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      if (FlushCycles > 1) begin
        state_nxt = REDIRECT;
        flush_nxt = FLUSH_RELOAD;
      end else begin
        state_nxt = RUN;
      end
    end else if (state == REDIRECT) begin
      flush_ifid = 1'b1;
      flush_nxt  = flush_cnt - 3'd1;
      if (flush_cnt == 3'd1) state_nxt = RUN;
    end else if ((state == RUN) && load_use) begin
      stall_front = 1'b1;
      flush_idex  = 1'b1;
      state_nxt   = LD_BUBBLE;
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      flush_cnt   <= flush_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  forward_unit #(
    .RegAddress(RegAddress)
  ) u_fwd (
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_valid     (ex_valid),
    .ex_load      (ex_load),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .mem_valid    (mem_valid),
    .mem_reg_write(mem_reg_write),
    .mem_rd       (mem_rd),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .fwd_a_sel    (fwd_a_raw),
    .fwd_b_sel    (fwd_b_raw)
  );

  // Outputs are forced quiet for as long as reset is held.
  assign pc_stall     = rst & (stall_all | stall_front);
  assign if_id_stall  = rst & (stall_all | stall_front);
  assign id_ex_stall  = rst & stall_all;
  assign ex_mem_stall = rst & stall_all;
  assign if_id_flush  = rst & flush_ifid;
  assign id_ex_flush  = rst & flush_idex;
  assign fwd_a_sel    = rst ? fwd_a_raw : FWD_RF;
  assign fwd_b_sel    = rst ? fwd_b_raw : FWD_RF;
  assign ctrl_state   = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_pipeline_hazard_ctrl;

  localparam int FC  = 2;
  localparam int MAX = 3;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic ex_valid, ex_load, ex_reg_write, mem_valid, mem_reg_write, wb_valid, wb_reg_write;
  logic redirect, dmem_req, dmem_ready;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel, ctrl_state;
  logic mem_timeout;

  logic [5:0] ctl;
  logic [3:0] fwd;
  assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush};
  assign fwd = {fwd_a_sel, fwd_b_sel};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what is pending, not how the RTL encodes it.
  int m_flush_left;
  int m_busy_n;
  bit m_bubble, m_wait, m_to;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.RegAddress(5), .FlushCycles(FC), .MemWaitMax(MAX)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .redirect(redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_timeout(mem_timeout), .ctrl_state(ctrl_state)
  );

  task step;
    @(posedge clk);
    #1;
  endtask

  task idle_inputs;
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_load = 0; ex_reg_write = 0; ex_rd = 0;
    mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
    wb_valid = 0; wb_reg_write = 0; wb_rd = 0;
    redirect = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task ref_reset;
    m_flush_left = 0; m_busy_n = 0; m_bubble = 0; m_wait = 0; m_to = 0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic u);
    logic [4:0] rd [3];
    logic       wr [3];
    if (!(id_valid && u) || rs == 5'd0) return 2'b00;
    rd = '{ex_rd, mem_rd, wb_rd};
    wr = '{ex_valid && ex_reg_write && !ex_load, mem_valid && mem_reg_write, wb_valid && wb_reg_write};
    for (int i = 0; i < 3; i++)
      if (wr[i] && rd[i] == rs) return 2'(i + 1);
    return 2'b00;
  endfunction

  // Expected outputs for the current cycle, then advance the model across the edge.
  task ref_cycle(output logic [5:0] ectl, output logic [1:0] est, output logic eto);
    bit busy, redir, lu;
    if (!rst) ref_reset();
    busy  = dmem_req && !dmem_ready;
    redir = redirect && ex_valid;
    lu = ex_valid && ex_load && ex_reg_write && ex_rd != 5'd0 && id_valid &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    est  = m_wait ? 2'd3 : (m_flush_left > 0 ? 2'd2 : (m_bubble ? 2'd1 : 2'd0));
    eto  = m_to;
    ectl = 6'b000000;
    if (!rst) return;
    if (m_wait) begin
      if (busy) begin
        ectl = 6'b111100;
        m_busy_n = (m_busy_n + 1 > MAX) ? MAX : m_busy_n + 1;
      end else begin
        m_wait = 0; m_busy_n = 0;
      end
    end else if (busy) begin
      ectl = 6'b111100; m_wait = 1; m_busy_n = 1; m_flush_left = 0; m_bubble = 0;
    end else if (redir) begin
      ectl = 6'b000011; m_flush_left = FC - 1; m_bubble = 0;
    end else if (m_flush_left > 0) begin
      ectl = 6'b000010; m_flush_left--;
    end else if (lu && !m_bubble) begin
      ectl = 6'b110001; m_bubble = 1;
    end else begin
      m_bubble = 0;
    end
    if (m_busy_n >= MAX) m_to = 1;
  endtask

  task test_reset;
    idle_inputs();
    rst = 1;
    #1 rst = 0;
    dmem_req = 1; redirect = 1; ex_valid = 1; ex_reg_write = 1; ex_rd = 3;
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 3;
    #1;
    vectors++; if (ctl !== 6'b0) begin miscompares++; $display("FAIL reset_ctl: got %b want %b", ctl, 6'b0); end
    vectors++; if (fwd !== 4'b0) begin miscompares++; $display("FAIL reset_fwd: got %b want %b", fwd, 4'b0); end
    vectors++; if (ctrl_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", ctrl_state); end
    vectors++; if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
    step();
    idle_inputs();
    rst = 1;
  endtask

  task test_load_use;
    idle_inputs();
    ex_valid = 1; ex_load = 1; ex_reg_write = 1; ex_rd = 5;
    id_valid = 1; id_rs1 = 5; id_rs2 = 1; id_use_rs1 = 1; id_use_rs2 = 1;
    #2;
    vectors++; if (ctl !== 6'b110001) begin miscompares++; $display("FAIL lu_ctl: got %b want %b", ctl, 6'b110001); end
    vectors++; if (ctrl_state !== 2'd0) begin miscompares++; $display("FAIL lu_state0: got %0d want 0", ctrl_state); end
    vectors++; if (fwd !== 4'b0000) begin miscompares++; $display("FAIL lu_fwd0: got %b want %b", fwd, 4'b0000); end
    step();
    ex_valid = 0; ex_load = 0; ex_reg_write = 0;
    mem_valid = 1; mem_reg_write = 1; mem_rd = 5;
    #2;
    vectors++; if (ctl !== 6'b0) begin miscompares++; $display("FAIL lu_bubble_ctl: got %b want %b", ctl, 6'b0); end
    vectors++; if (ctrl_state !== 2'd1) begin miscompares++; $display("FAIL lu_state1: got %0d want 1", ctrl_state); end
    vectors++; if (fwd_a_sel !== 2'b10) begin miscompares++; $display("FAIL lu_fwd_a: got %b want 10", fwd_a_sel); end
    step();
    idle_inputs();
    #2;
    vectors++; if (ctrl_state !== 2'd0) begin miscompares++; $display("FAIL lu_state2: got %0d want 0", ctrl_state); end
    step();
  endtask

  task test_redirect;
    idle_inputs();
    redirect = 1; ex_valid = 1;
    #2;
    vectors++; if (ctl !== 6'b000011) begin miscompares++; $display("FAIL redir_c0: got %b want %b", ctl, 6'b000011); end
    step();
    idle_inputs();
    #2;
    vectors++; if (ctl !== 6'b000010) begin miscompares++; $display("FAIL redir_c1: got %b want %b", ctl, 6'b000010); end
    vectors++; if (ctrl_state !== 2'd2) begin miscompares++; $display("FAIL redir_state1: got %0d want 2", ctrl_state); end
    step();
    #2;
    vectors++; if (ctl !== 6'b0) begin miscompares++; $display("FAIL redir_c2: got %b want %b", ctl, 6'b0); end
    vectors++; if (ctrl_state !== 2'd0) begin miscompares++; $display("FAIL redir_state2: got %0d want 0", ctrl_state); end
    step();
  endtask

  task test_mem_wait;
    logic want_to;
    idle_inputs();
    dmem_req = 1;
    for (int i = 0; i < 5; i++) begin
      #2;
      want_to = (i >= MAX);
      vectors++; if (ctl !== 6'b111100) begin miscompares++; $display("FAIL mw_ctl[%0d]: got %b want %b", i, ctl, 6'b111100); end
      vectors++; if (mem_timeout !== want_to) begin miscompares++; $display("FAIL mw_timeout[%0d]: got %b want %b", i, mem_timeout, want_to); end
      vectors++; if (ctrl_state !== (i == 0 ? 2'd0 : 2'd3)) begin miscompares++; $display("FAIL mw_state[%0d]: got %0d", i, ctrl_state); end
      step();
    end
    dmem_ready = 1;
    #2;
    vectors++; if (ctl !== 6'b0) begin miscompares++; $display("FAIL mw_release_ctl: got %b want %b", ctl, 6'b0); end
    vectors++; if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL mw_release_to: got %b want 1", mem_timeout); end
    step();
    idle_inputs();
    #2;
    vectors++; if (ctrl_state !== 2'd0) begin miscompares++; $display("FAIL mw_after_state: got %0d want 0", ctrl_state); end
    vectors++; if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL mw_sticky: got %b want 1", mem_timeout); end
    step();
  endtask

  task test_forwarding;
    idle_inputs();
    ex_valid = 1; ex_reg_write = 1; ex_rd = 7;
    mem_valid = 1; mem_reg_write = 1; mem_rd = 7;
    wb_valid = 1; wb_reg_write = 1; wb_rd = 7;
    id_valid = 1; id_rs2 = 7; id_use_rs2 = 1; id_rs1 = 7; id_use_rs1 = 0;
    #2;
    vectors++; if (fwd !== 4'b0001) begin miscompares++; $display("FAIL fwd_ex: got %b want %b", fwd, 4'b0001); end
    step(); ex_reg_write = 0; #2;
    vectors++; if (fwd !== 4'b0010) begin miscompares++; $display("FAIL fwd_mem: got %b want %b", fwd, 4'b0010); end
    step(); mem_valid = 0; #2;
    vectors++; if (fwd !== 4'b0011) begin miscompares++; $display("FAIL fwd_wb: got %b want %b", fwd, 4'b0011); end
    step(); id_use_rs1 = 1; #2;
    vectors++; if (fwd !== 4'b1111) begin miscompares++; $display("FAIL fwd_both: got %b want %b", fwd, 4'b1111); end
    step(); id_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0; #2;
    vectors++; if (fwd_b_sel !== 2'b00) begin miscompares++; $display("FAIL fwd_x0: got %b want 00", fwd_b_sel); end
    step(); id_rs2 = 7; wb_rd = 7; id_use_rs2 = 0; #2;
    vectors++; if (fwd_b_sel !== 2'b00) begin miscompares++; $display("FAIL fwd_unused: got %b want 00", fwd_b_sel); end
    step();
  endtask

  task test_simultaneous;
    idle_inputs();
    redirect = 1; ex_valid = 1; ex_load = 1; ex_reg_write = 1; ex_rd = 5;
    id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
    #2;
    vectors++; if (ctl !== 6'b000011) begin miscompares++; $display("FAIL sim_redir_lu: got %b want %b", ctl, 6'b000011); end
    step(); idle_inputs(); step();
    #2;
    vectors++; if (ctrl_state !== 2'd0) begin miscompares++; $display("FAIL sim_settle: got %0d want 0", ctrl_state); end
    step();
    redirect = 1; ex_valid = 1; dmem_req = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      vectors++; if (ctl !== 6'b111100) begin miscompares++; $display("FAIL sim_mem_redir[%0d]: got %b want %b", i, ctl, 6'b111100); end
      step();
    end
    dmem_ready = 1;
    #2;
    vectors++; if (ctl !== 6'b0) begin miscompares++; $display("FAIL sim_release: got %b want %b", ctl, 6'b0); end
    step();
    dmem_req = 0; dmem_ready = 0;
    #2;
    vectors++; if (ctl !== 6'b000011) begin miscompares++; $display("FAIL sim_late_flush: got %b want %b", ctl, 6'b000011); end
    step(); idle_inputs(); step(); step();
  endtask

  task test_reset_mid;
    logic want_to;
    idle_inputs();
    dmem_req = 1;
    step(); step();
    #1;
    vectors++; if (ctrl_state !== 2'd3) begin miscompares++; $display("FAIL rm_state_pre: got %0d want 3", ctrl_state); end
    vectors++; if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL rm_to_pre: got %b want 1", mem_timeout); end
    rst = 0;
    #1;
    vectors++; if (ctl !== 6'b0) begin miscompares++; $display("FAIL rm_ctl: got %b want %b", ctl, 6'b0); end
    vectors++; if (ctrl_state !== 2'd0) begin miscompares++; $display("FAIL rm_state: got %0d want 0", ctrl_state); end
    vectors++; if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL rm_to: got %b want 0", mem_timeout); end
    step();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      want_to = (i >= MAX);
      vectors++; if (mem_timeout !== want_to) begin miscompares++; $display("FAIL rm_recount[%0d]: got %b want %b", i, mem_timeout, want_to); end
      step();
    end
    idle_inputs();
    step();
  endtask

  task test_random;
    logic [5:0] e_ctl;
    logic [1:0] e_st;
    logic       e_to;
    logic [3:0] e_fwd;
    for (int n = 0; n < 900; n++) begin
      rst = (n % 150 == 0) ? 1'b0 : 1'b1;
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_use_rs1 = ($urandom_range(0, 3) != 0); id_use_rs2 = ($urandom_range(0, 1) != 0);
      ex_valid = ($urandom_range(0, 3) != 0); ex_load = ($urandom_range(0, 2) == 0);
      ex_reg_write = ($urandom_range(0, 3) != 0); ex_rd = 5'($urandom_range(0, 3));
      mem_valid = ($urandom_range(0, 1) != 0); mem_reg_write = ($urandom_range(0, 1) != 0);
      mem_rd = 5'($urandom_range(0, 3));
      wb_valid = ($urandom_range(0, 1) != 0); wb_reg_write = ($urandom_range(0, 1) != 0);
      wb_rd = 5'($urandom_range(0, 3));
      redirect = ($urandom_range(0, 5) == 0);
      dmem_req = ($urandom_range(0, 3) == 0); dmem_ready = ($urandom_range(0, 1) != 0);
      #2;
      e_fwd = rst ? {ref_fwd(id_rs1, id_use_rs1), ref_fwd(id_rs2, id_use_rs2)} : 4'b0;
      ref_cycle(e_ctl, e_st, e_to);
      vectors++; if (ctl !== e_ctl) begin miscompares++; $display("FAIL rand_ctl cyc %0d: got %b want %b", n, ctl, e_ctl); end
      vectors++; if (fwd !== e_fwd) begin miscompares++; $display("FAIL rand_fwd cyc %0d: got %b want %b", n, fwd, e_fwd); end
      vectors++; if (ctrl_state !== e_st) begin miscompares++; $display("FAIL rand_state cyc %0d: got %0d want %0d", n, ctrl_state, e_st); end
      vectors++; if (mem_timeout !== e_to) begin miscompares++; $display("FAIL rand_timeout cyc %0d: got %b want %b", n, mem_timeout, e_to); end
      step();
    end
    idle_inputs();
    rst = 1;
  endtask

  initial begin
    ref_reset();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_forwarding();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It watches register addresses and control flags from the decode, execute, memory and writeback stages, and drives the stall/flush enables of the PC and pipeline registers. It also drives the operand-forwarding selects for the decode-stage operand muxes. An internal FSM handles multi-cycle events: load-use bubble, redirect flush window and data-memory wait with timeout.

Parameters:
RegAddress, 5, register index width
FlushCycles, 2, cycles IF/ID is flushed after a redirect (1..7)
MemWaitMax, 15, MEM_WAIT cycles before mem_timeout asserts (1..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
id_valid  input  1  ID holds a valid instruction
id_rs1, id_rs2  input  RegAddress  ID source registers
id_use_rs1, id_use_rs2  input  1  ID instruction reads rs1/rs2
ex_valid, ex_load, ex_reg_write  input  1  EX stage flags
ex_rd  input  RegAddress  EX destination
mem_valid, mem_reg_write  input  1  MEM stage flags
mem_rd  input  RegAddress  MEM destination
wb_valid, wb_reg_write  input  1  WB stage flags
wb_rd  input  RegAddress  WB destination
redirect  input  1  taken branch/jal/jalr resolved in EX
dmem_req, dmem_ready  input  1  data-memory request / completion
pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  output  1  hold the register
if_id_flush, id_ex_flush  output  1  load a bubble into the register
fwd_a_sel, fwd_b_sel  output  2  00 regfile, 01 EX, 10 MEM, 11 WB
mem_timeout  output  1  sticky data-memory timeout
ctrl_state  output  2  current FSM state, for debug

Behaviour:
- Reset (rst=0, async):
  - state=RUN; flush and wait counters cleared; mem_timeout=0.
  - While rst=0, all stall/flush outputs are 0 and fwd selects are 00.
- Stall, flush and fwd outputs are combinational (Mealy) from state and inputs, so they act in the same cycle. State and counters update on rising clk.
- Hazard definitions:
  - match(r, x) = id_valid & use_x & (r == id_x) & (r != 0).
  - load_use = ex_valid & ex_load & ex_reg_write & match(ex_rd, rs1 or rs2).
  - mem_busy = dmem_req & ~dmem_ready.
- Priority: mem_busy > redirect > load_use.
- States: RUN=0, LD_BUBBLE=1, REDIRECT=2, MEM_WAIT=3.
- RUN:
  - mem_busy: assert all four stalls, no flush; go to MEM_WAIT; wait counter = 1.
  - else redirect & ex_valid: assert if_id_flush and id_ex_flush; go to REDIRECT if FlushCycles > 1 (flush counter = FlushCycles-1), else stay in RUN.
  - else load_use: assert pc_stall, if_id_stall and id_ex_flush for exactly one cycle; go to LD_BUBBLE.
  - else no action.
- LD_BUBBLE: load_use detection is suppressed. mem_busy is handled as in RUN, otherwise return to RUN. redirect in this cycle is handled as in RUN.
- REDIRECT:
  - Assert if_id_flush each cycle; decrement the counter; return to RUN when it reaches 0.
  - A new redirect reloads the counter to FlushCycles-1.
  - mem_busy takes priority: go to MEM_WAIT; the remaining flush count is dropped.
- MEM_WAIT:
  - Assert all four stalls, no flushes. Wait counter increments and saturates at MemWaitMax.
  - mem_timeout sets when the counter reaches MemWaitMax and stays set until reset. The FSM keeps waiting.
  - When dmem_ready=1 or dmem_req=0: release stalls in that cycle and return to RUN.
  - A redirect held during the wait is acted on in the first RUN cycle, because the frozen EX stage still presents it.
- Forwarding, per operand:
  - 01 if ex_valid & ex_reg_write & ~ex_load & match(ex_rd); else 10 if mem_valid & mem_reg_write & match(mem_rd); else 11 if wb_valid & wb_reg_write & match(wb_rd); else 00.
  - Youngest producer wins. Register x0 always yields 00. When use_x=0, the select is 00.
- Simultaneous redirect and load_use: redirect wins and no stall is asserted, because the younger instruction is squashed.

Decomposition:
- Package pipeline_ctrl_pkg: ctrl_state_e enum (RUN, LD_BUBBLE, REDIRECT, MEM_WAIT); fwd select constants FWD_RF, FWD_EX, FWD_MEM, FWD_WB.
- Sub-module forward_unit: purely combinational. Instantiated once and produces both fwd_a_sel and fwd_b_sel.
- FSM, counters and stall/flush logic live in the top module.

Test Plan:
- Load-use: EX lw x5 (ex_load=1, ex_rd=5), ID add x6,x5,x1 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; ctrl_state 0→1→0; next cycle fwd_a_sel=10 once the load reaches MEM.
- Redirect, FlushCycles=2: redirect=1, ex_valid=1 in RUN -> cycle0 if_id_flush=1 and id_ex_flush=1; cycle1 if_id_flush=1 only; cycle2 all 0, state RUN.
- Memory wait with MemWaitMax=3: dmem_req=1, dmem_ready=0 for 5 cycles -> all stalls=1 throughout; mem_timeout rises on the 3rd cycle and stays 1 after dmem_ready=1 until rst=0.
- Forwarding priority: ex_rd=mem_rd=wb_rd=7, all writing, id_rs2=7, use_rs2=1 -> fwd_b_sel=01. With ex_reg_write=0 -> 10. With id_rs2=0 -> 00.
- Simultaneous events: redirect=1 and load_use in the same RUN cycle -> flushes only, pc_stall=0. mem_busy with redirect -> stalls only; flushes appear in the cycle after dmem_ready=1.
- Reset mid-operation: drop rst in MEM_WAIT with the counter at 2 -> outputs 0 immediately (asynchronous); after release, state=RUN, mem_timeout=0, counter=0.
